// File: rtl/mux_grant_sched_pkg.sv
// mux_grant_sched_pkg.sv - shared state encodings and enable polarity for the mux grant scheduler
package mux_grant_sched_pkg;

    // Scheduler states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Mux enable is active-low
    localparam logic E_ON  = 1'b0;
    localparam logic E_OFF = 1'b1;

endpackage

// File: rtl/mux_grant_sched_rr_pick.sv
// mux_grant_sched_rr_pick.sv - combinational round-robin picker
// Ports:
//   req     in   N      request vector
//   ptr     in   SEL_W  index of last owner (lowest priority)
//   winner  out  SEL_W  first requester found scanning ptr+1, ptr+2 .. mod N
//   any_req out  1      at least one request is set
module mux_grant_sched_rr_pick #(
    parameter int N     = 2,
    parameter int SEL_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any_req
);

    int idx;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        // Offset 1..N so the previous owner is examined last
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_grant_sched.sv
// mux_grant_sched.sv - round-robin grant scheduler driving a shared mux select/enable
// Optional feature macro: TIMEOUT_EN (force release after MAX_HOLD grant cycles)
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous active-high reset
//   req   in   N      level request per requester
//   done  in   N      release pulse, honoured only for the current owner
//   gnt   out  N      registered one-hot grant, zero when no owner
//   S     out  SEL_W  mux select = owner index, holds while E=1
//   E     out  1      active-low mux enable, low only while gnt != 0
//   busy  out  1      high in GRANT and GAP states
module mux_grant_sched
    import mux_grant_sched_pkg::*;
#(
    parameter int N        = 2,
    parameter int SEL_W    = 1,
    parameter int GAP      = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     done,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] S,
    output logic             E,
    output logic             busy
);

    localparam int GAP_W = $clog2(GAP + 1);

    state_t             state_q, state_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic [SEL_W-1:0]   s_q, s_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               e_q, busy_q;
    logic [SEL_W-1:0]   winner;
    logic               any_req;
    logic               release_now;

`ifdef TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0]  hold_q, hold_d;
`endif

    mux_grant_sched_rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        s_d         = s_q;
        ptr_d       = ptr_q;
        gap_d       = gap_q;
        release_now = done[s_q] | ~req[s_q];
`ifdef TIMEOUT_EN
        hold_d      = hold_q;
        release_now = release_now | (hold_q == HOLD_W'(MAX_HOLD - 1));
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_GRANT;
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << winner;
                    s_d     = winner;
                    ptr_d   = winner;
`ifdef TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    state_d = ST_GAP;
                    gnt_d   = '0;
                    gap_d   = '0;
                end
`ifdef TIMEOUT_EN
                else if (hold_q != HOLD_W'(MAX_HOLD)) begin
                    hold_d = hold_q + 1'b1;
                end
`endif
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP - 1)) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            s_q     <= '0;
            ptr_q   <= SEL_W'(N - 1);
            gap_q   <= '0;
            e_q     <= E_OFF;
            busy_q  <= 1'b0;
`ifdef TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            gap_q   <= gap_d;
            // Enable derived from next grant so E tracks gnt in the same cycle
            e_q     <= (gnt_d == '0) ? E_OFF : E_ON;
            busy_q  <= (state_d != ST_IDLE);
`ifdef TIMEOUT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign S    = s_q;
    assign E    = e_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mux_grant_sched.sv
// tb/tb_mux_grant_sched.sv - self-checking bench for mux_grant_sched (N=2, GAP=1, MAX_HOLD=4)
module tb_mux_grant_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] done;
    logic [1:0] gnt;
    logic [0:0] S;
    logic       E;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0] req;
        logic [1:0] done;
        logic [1:0] gnt;
        logic       s;
        logic       e;
        logic       busy;
    } vec_t;

    vec_t vecs[17];

    logic [23:0] e_hist;
    logic [23:0] e_exp;

    mux_grant_sched #(
        .N        (2),
        .SEL_W    (1),
        .GAP      (1),
        .MAX_HOLD (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .done (done),
        .gnt  (gnt),
        .S    (S),
        .E    (E),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] g, input logic s,
                             input logic e, input logic b);
        check({tag, "_gnt"},  32'(gnt),  32'(g));
        check({tag, "_S"},    32'(S),    32'(s));
        check({tag, "_E"},    32'(E),    32'(e));
        check({tag, "_busy"}, 32'(busy), 32'(b));
    endtask

    initial begin
        //            req    done   gnt    S     E     busy
        vecs[0]  = '{2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1}; // first grant to 0
        vecs[1]  = '{2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1}; // done -> GAP
        vecs[2]  = '{2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0}; // GAP -> IDLE
        vecs[3]  = '{2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1}; // sole requester re-granted
        vecs[4]  = '{2'b11, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1}; // release wins over req high
        vecs[5]  = '{2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{2'b11, 2'b00, 2'b10, 1'b1, 1'b0, 1'b1}; // round-robin to 1
        vecs[7]  = '{2'b11, 2'b01, 2'b10, 1'b1, 1'b0, 1'b1}; // done of non-owner ignored
        vecs[8]  = '{2'b11, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1}; // S held during gap
        vecs[9]  = '{2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{2'b11, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1}; // back to 0
        vecs[11] = '{2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1}; // req drop releases
        vecs[12] = '{2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{2'b10, 2'b00, 2'b10, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1};
        vecs[15] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0}; // idle with no request

        rst  = 1'b1;
        req  = 2'b00;
        done = 2'b00;
        #12;
        check_all("reset", 2'b00, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            req  = vecs[i].req;
            done = vecs[i].done;
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].s, vecs[i].e, vecs[i].busy);
        end

        // Asynchronous reset while requester 1 owns the mux
        req  = 2'b10;
        done = 2'b00;
        @(negedge clk);
        check_all("pre_rst", 2'b10, 1'b1, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 2'b00, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        req = 2'b11;
        @(negedge clk);
        check_all("post_rst", 2'b01, 1'b0, 1'b0, 1'b1);

        // Long hold with no done
        req = 2'b00;
        @(negedge clk);
        check_all("hold_rel", 2'b00, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        req = 2'b01;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            e_hist[i] = E;
`ifdef TIMEOUT_EN
            e_exp[i] = ((i % 6) >= 4);
`else
            e_exp[i] = 1'b0;
`endif
        end
        check("hold_E_pattern", 32'(e_hist), 32'(e_exp));
        check("hold_S", 32'(S), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
